// File: rtl/s27_window_driver.sv
`default_nettype none
// ============================================================================
// Module   : s27_window_driver
// Purpose  : Sequential front-end for a FRAMES-deep unrolled s27 block.
//            Packs consecutive G0..G3 input vectors into a window, presents
//            the window plus the current register state to the unrolled
//            block, captures the per-frame G17 results and the final
//            next-state, and serialises G17 back out one frame at a time.
//            The captured next-state seeds the following window, so a stream
//            of windows behaves like the sequential s27 circuit.
// Ports    : clk, rst_n           clock, asynchronous active-low reset
//            in_valid/in_ready    input vector handshake
//            in_vec[3:0]          bit i = Gi
//            in_last              final vector of a sequence
//            win_vec[4*FRAMES-1:0] frame k in bits [4k+3:4k]
//            win_state[2:0]       initial register state for the window
//            win_valid            window stable, waiting for a result
//            res_valid            result from the unrolled block is valid
//            res_g17[FRAMES-1:0]  bit k = G17 of frame k
//            res_state[2:0]       next-state after the last frame
//            out_valid/out_ready  G17 result handshake
//            out_g17              G17 of the current frame
//            out_last             last result of an in_last sequence
// Revision : 1.0 - initial release
// ============================================================================
module s27_window_driver #(
    parameter int         FRAMES     = 5,
    parameter logic [2:0] INIT_STATE = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_vec,
    input  logic                  in_last,
    output logic [4*FRAMES-1:0]   win_vec,
    output logic [2:0]            win_state,
    output logic                  win_valid,
    input  logic                  res_valid,
    input  logic [FRAMES-1:0]     res_g17,
    input  logic [2:0]            res_state,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_g17,
    output logic                  out_last
);

    localparam int CW = $clog2(FRAMES + 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              r_fsm;
    state_t              w_fsm_nxt;

    logic [CW-1:0]       r_cnt;        // vectors accepted into the current window
    logic [CW-1:0]       r_nvalid;     // number of real (non-padded) frames
    logic [CW-1:0]       r_idx;        // drain position
    logic [4*FRAMES-1:0] r_win_vec;
    logic [2:0]          r_dff_state;  // running s27 register state
    logic [2:0]          r_win_state;  // snapshot presented with the window
    logic                r_last_flag;
    logic [FRAMES-1:0]   r_g17;

    logic                w_accept;
    logic [CW-1:0]       w_cnt_inc;
    logic                w_fill_done;
    logic                w_capture;
    logic                w_drain_last;
    logic                w_drain_done;

    assign w_accept     = in_valid && (r_fsm == FILL);
    assign w_cnt_inc    = r_cnt + CW'(1);
    assign w_fill_done  = w_accept && ((w_cnt_inc == CW'(FRAMES)) || in_last);
    assign w_capture    = res_valid && (r_fsm == ISSUE);
    assign w_drain_last = (r_idx == (r_nvalid - CW'(1)));
    assign w_drain_done = (r_fsm == DRAIN) && out_ready && w_drain_last;

    assign win_vec   = r_win_vec;
    assign win_state = r_win_state;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= FILL;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_fsm_nxt = r_fsm;
        in_ready  = 1'b0;
        win_valid = 1'b0;
        out_valid = 1'b0;
        out_g17   = 1'b0;
        out_last  = 1'b0;
        case (r_fsm)
            FILL: begin
                in_ready = 1'b1;
                if (w_fill_done) begin
                    w_fsm_nxt = ISSUE;
                end
            end
            ISSUE: begin
                win_valid = 1'b1;
                if (w_capture) begin
                    w_fsm_nxt = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_g17   = r_g17[r_idx];
                out_last  = r_last_flag && w_drain_last;
                if (w_drain_done) begin
                    w_fsm_nxt = FILL;
                end
            end
            default: begin
                w_fsm_nxt = FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_nvalid    <= '0;
            r_idx       <= '0;
            r_win_vec   <= '0;
            r_dff_state <= INIT_STATE;
            r_win_state <= INIT_STATE;
            r_last_flag <= 1'b0;
            r_g17       <= '0;
        end else begin
            case (r_fsm)
                FILL: begin
                    if (w_accept) begin
                        for (int k = 0; k < FRAMES; k++) begin
                            if (r_cnt == CW'(k)) begin
                                r_win_vec[4*k +: 4] <= in_vec;
                            end
                        end
                        r_cnt <= w_cnt_inc;
                        if (w_fill_done) begin
                            r_nvalid    <= w_cnt_inc;
                            r_last_flag <= in_last;
                            // Snapshot taken on ISSUE entry only, so the
                            // window always carries the pre-window state.
                            r_win_state <= r_dff_state;
                        end
                    end
                end
                ISSUE: begin
                    if (res_valid) begin
                        r_g17       <= res_g17;
                        // A finished sequence restarts from the initial state.
                        r_dff_state <= r_last_flag ? INIT_STATE : res_state;
                        r_idx       <= '0;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (w_drain_last) begin
                            // Clearing the slots makes short windows pad with 0.
                            r_cnt       <= '0;
                            r_win_vec   <= '0;
                            r_last_flag <= 1'b0;
                            r_idx       <= '0;
                        end else begin
                            r_idx <= r_idx + CW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_s27_window_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_s27_window_driver
// Purpose  : Self-checking bench for s27_window_driver. Acts as the unrolled
//            s27 block, drives directed windows from a table, runs the
//            multi-cycle corner cases by hand and finishes with a random
//            end-to-end stream checked against a sequential golden s27 model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_s27_window_driver;

    localparam int         FRAMES = 5;
    localparam logic [2:0] INIT   = 3'b000;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_vec;
    logic        in_last;
    logic [19:0] win_vec;
    logic [2:0]  win_state;
    logic        win_valid;
    logic        res_valid;
    logic [4:0]  res_g17;
    logic [2:0]  res_state;
    logic        out_valid;
    logic        out_ready;
    logic        out_g17;
    logic        out_last;

    s27_window_driver #(.FRAMES(FRAMES), .INIT_STATE(INIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .in_last   (in_last),
        .win_vec   (win_vec),
        .win_state (win_state),
        .win_valid (win_valid),
        .res_valid (res_valid),
        .res_g17   (res_g17),
        .res_state (res_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_g17   (out_g17),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] sb_q[$];   // {g17, last}
    logic       e2e_done;

    typedef struct {
        int          n;
        logic [3:0]  vec;
        logic        last;
        logic [4:0]  g17;
        logic [2:0]  rs;
        logic [19:0] exp_wv;
        logic [2:0]  exp_ws;
    } rec_t;

    rec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One s27 frame: returns {D2,D1,D0,G17}; state bits {G7,G6,G5}.
    function automatic logic [3:0] s27(input logic [3:0] g, input logic [2:0] s);
        logic a, b, g17, d0, d1, d2;
        a   = ~g[1] & g[3] & ~s[2];
        b   = ~((s[1] & ~g[0]) | a);
        g17 = s[0] | b;
        d0  = g[0] & ~(~s[0] & a);
        d1  = ~(s[0] | b);
        d2  = ~(g[2] | ~(g[1] | s[2]));
        return {d2, d1, d0, g17};
    endfunction

    // Unrolled block: returns {final_state, g17[4:0]}.
    function automatic logic [7:0] unroll(input logic [19:0] wv, input logic [2:0] st);
        logic [2:0] s;
        logic [4:0] g;
        logic [3:0] r;
        s = st;
        g = '0;
        for (int k = 0; k < FRAMES; k++) begin
            r    = s27(wv[4*k +: 4], s);
            g[k] = r[0];
            s    = r[3:1];
        end
        return {s, g};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_vec    = '0;
        res_valid = 1'b0;
        res_g17   = '0;
        res_state = '0;
        out_ready = 1'b0;
        sb_q.delete();
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic send_vec(input logic [3:0] v, input logic l);
        int bud;
        in_vec   = v;
        in_last  = l;
        in_valid = 1'b1;
        bud      = 200;
        while (!in_ready && bud > 0) begin
            cyc();
            bud--;
        end
        if (bud == 0) chk("in_ready_timeout", 0, 1);
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic give_result(input logic [4:0] g, input logic [2:0] s);
        res_g17   = g;
        res_state = s;
        res_valid = 1'b1;
        cyc();
        res_valid = 1'b0;
    endtask

    task automatic push_exp(input int n, input logic [4:0] g, input logic l);
        for (int k = 0; k < n; k++) begin
            sb_q.push_back({g[k], l && (k == n - 1)});
        end
    endtask

    task automatic drain_all();
        int         bud;
        logic [1:0] e;
        out_ready = 1'b1;
        bud       = 200;
        while (sb_q.size() > 0 && bud > 0) begin
            if (out_valid) begin
                e = sb_q.pop_front();
                chk("drain_g17", {31'd0, out_g17}, {31'd0, e[1]});
                chk("drain_last", {31'd0, out_last}, {31'd0, e[0]});
            end
            cyc();
            bud--;
        end
        if (bud == 0) chk("drain_timeout", 0, 1);
        out_ready = 1'b0;
        chk("back_to_fill", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [2:0] gst;
        logic [3:0] r;
        logic [3:0] v;
        logic       l;
        logic [4:0] pat_exp;
        logic [6:0] pat_rdy;
        int         idx;
        int         c;

        tbl[0] = '{5, 4'h9, 1'b0, 5'b00000, 3'b010, 20'h99999, 3'b000};
        tbl[1] = '{5, 4'h9, 1'b0, 5'b10110, 3'b101, 20'h99999, 3'b010};
        tbl[2] = '{3, 4'hA, 1'b1, 5'b11010, 3'b111, 20'h00AAA, 3'b101};
        tbl[3] = '{1, 4'h5, 1'b1, 5'b00001, 3'b011, 20'h00005, 3'b000};
        tbl[4] = '{5, 4'h3, 1'b1, 5'b01101, 3'b110, 20'h33333, 3'b000};
        tbl[5] = '{5, 4'hC, 1'b0, 5'b10000, 3'b100, 20'hCCCCC, 3'b000};
        e2e_done = 1'b0;

        // Reset values, checked while reset is held
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_vec    = '0;
        res_valid = 1'b0;
        res_g17   = '0;
        res_state = '0;
        out_ready = 1'b0;
        #3;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_win_valid", {31'd0, win_valid}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_g17", {31'd0, out_g17}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_win_vec", {12'd0, win_vec}, 32'd0);
        chk("rst_win_state", {29'd0, win_state}, {29'd0, INIT});
        do_reset();

        // Table-driven windows
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < tbl[t].n; k++) begin
                send_vec(tbl[t].vec, tbl[t].last && (k == tbl[t].n - 1));
            end
            chk("tbl_win_valid", {31'd0, win_valid}, 32'd1);
            chk("tbl_in_ready", {31'd0, in_ready}, 32'd0);
            chk("tbl_win_vec", {12'd0, win_vec}, {12'd0, tbl[t].exp_wv});
            chk("tbl_win_state", {29'd0, win_state}, {29'd0, tbl[t].exp_ws});
            give_result(tbl[t].g17, tbl[t].rs);
            push_exp(tbl[t].n, tbl[t].g17, tbl[t].last);
            drain_all();
        end

        // ISSUE held with no result, then stalled drain
        for (int k = 0; k < 5; k++) send_vec(4'h7, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("hold_win_valid", {31'd0, win_valid}, 32'd1);
            chk("hold_win_vec", {12'd0, win_vec}, 32'h77777);
            chk("hold_win_state", {29'd0, win_state}, 32'd4);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd0);
            cyc();
        end
        give_result(5'b10110, 3'b110);
        pat_exp = 5'b10110;
        pat_rdy = 7'b1111001;   // cycle c uses bit c: 1,0,0,1,1,1,1
        idx     = 0;
        c       = 0;
        while (idx < 5 && c < 20) begin
            out_ready = (c < 7) ? pat_rdy[c] : 1'b1;
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_out_g17", {31'd0, out_g17}, {31'd0, pat_exp[idx]});
            if (out_ready) idx++;
            cyc();
            c++;
        end
        out_ready = 1'b0;
        chk("stall_count", idx, 5);
        chk("stall_fill", {31'd0, in_ready}, 32'd1);
        chk("stall_out_done", {31'd0, out_valid}, 32'd0);

        // Reset asserted in the middle of a drain
        for (int k = 1; k <= 5; k++) send_vec(k[3:0], 1'b0);
        chk("mid_win_vec", {12'd0, win_vec}, 32'h54321);
        chk("mid_win_state", {29'd0, win_state}, 32'd6);
        give_result(5'b00011, 3'b011);
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("mid_out_g17", {31'd0, out_g17}, 32'd1);
            cyc();
        end
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_in_ready", {31'd0, in_ready}, 32'd1);
        chk("async_win_vec", {12'd0, win_vec}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        send_vec(4'h7, 1'b0);
        send_vec(4'h8, 1'b0);
        send_vec(4'h9, 1'b0);
        send_vec(4'hA, 1'b0);
        send_vec(4'hB, 1'b0);
        chk("post_rst_win_vec", {12'd0, win_vec}, 32'hBA987);
        chk("post_rst_win_state", {29'd0, win_state}, 32'd0);
        give_result(5'b00101, 3'b000);
        push_exp(5, 5'b00101, 1'b0);
        drain_all();

        // Random end-to-end stream against the golden sequential model
        do_reset();
        gst = INIT;
        fork
            begin : feeder
                int bud;
                int gap;
                for (int i = 0; i < 200; i++) begin
                    gap = $urandom_range(0, 2);
                    for (int j = 0; j < gap; j++) cyc();
                    v        = 4'($urandom);
                    l        = ($urandom_range(0, 7) == 0) || (i == 199);
                    in_vec   = v;
                    in_last  = l;
                    in_valid = 1'b1;
                    bud      = 1000;
                    while (!in_ready && bud > 0) begin
                        cyc();
                        bud--;
                    end
                    if (bud == 0) begin
                        chk("e2e_accept_timeout", 0, 1);
                        break;
                    end
                    cyc();
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                    r        = s27(v, gst);
                    sb_q.push_back({r[0], l});
                    gst = l ? INIT : r[3:1];
                end
            end
            begin : block
                int bud;
                int d;
                bud = 30000;
                while (!e2e_done && bud > 0) begin
                    if (win_valid) begin
                        d = $urandom_range(0, 3);
                        for (int j = 0; j < d; j++) cyc();
                        {res_state, res_g17} = unroll(win_vec, win_state);
                        res_valid = 1'b1;
                        cyc();
                        res_valid = 1'b0;
                    end else begin
                        cyc();
                    end
                    bud--;
                end
            end
            begin : consumer
                int         got;
                int         bud;
                logic [1:0] e;
                got = 0;
                bud = 20000;
                while (got < 200 && bud > 0) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        if (sb_q.size() == 0) begin
                            chk("e2e_unexpected_output", 1, 0);
                        end else begin
                            e = sb_q.pop_front();
                            chk("e2e_g17", {31'd0, out_g17}, {31'd0, e[1]});
                            chk("e2e_last", {31'd0, out_last}, {31'd0, e[0]});
                        end
                        got++;
                    end
                    cyc();
                    bud--;
                end
                if (bud == 0) chk("e2e_output_timeout", got, 200);
                out_ready = 1'b0;
                e2e_done  = 1'b1;
            end
        join
        chk("e2e_queue_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
